// File: rtl/gpio_channel_pkg.sv
// rtl/gpio_channel_pkg.sv - shared states and sizes for the GPIO channel endpoint.
package gpio_channel_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_WAIT,
    RX_SAMPLE,
    RX_HOLD
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP,
    TX_WAIT_ACK
  } tx_state_t;
endpackage

// File: rtl/flicker_detect.sv
// rtl/flicker_detect.sv - toggle-to-pulse detector for one flicker line.
// GPIO_CHANNEL_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module flicker_detect (
  input  logic clk,
  input  logic reset_n_i,
  input  logic flicker_i,
  output logic event_o
);
  logic w_in;
  logic r_cur;
  logic r_prev;

`ifdef GPIO_CHANNEL_SYNC_EN
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= flicker_i;
    end
  end

  assign w_in = r_sync;
`else
  assign w_in = flicker_i;
`endif

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= w_in;
      r_prev <= r_cur;
    end
  end

  // Either toggle direction is one event.
  assign event_o = r_cur ^ r_prev;
endmodule

// File: rtl/gpio_channel_endpoint.sv
// rtl/gpio_channel_endpoint.sv - flicker-handshaked byte channel to/from 32-bit words.
// Build option GPIO_CHANNEL_SYNC_EN selects synchronized flicker inputs.
module gpio_channel_endpoint
  import gpio_channel_pkg::*;
#(
  parameter int unsigned FLICKER_GAP = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic [7:0]  chan_rx_data_i,
  input  logic        usb_write_flicker_i,
  output logic        pulpino_read_flicker_o,
  output logic [7:0]  chan_tx_data_o,
  output logic        pulpino_write_flicker_o,
  input  logic        usb_read_flicker_i,
  output logic [31:0] rx_word_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [31:0] tx_word_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o
);
  localparam logic [CNT_W-1:0] GAP      = CNT_W'(FLICKER_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic w_wr_evt;
  logic w_rd_evt;

  flicker_detect u_wr_detect (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .flicker_i (usb_write_flicker_i),
    .event_o   (w_wr_evt)
  );

  flicker_detect u_rd_detect (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .flicker_i (usb_read_flicker_i),
    .event_o   (w_rd_evt)
  );

  rx_state_t         r_rx_state, w_rx_next;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [IDX_W-1:0]  r_rx_idx;
  logic              r_rx_pend;
  logic [31:0]       r_rx_word;
  logic              r_rd_flk;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (w_wr_evt || r_rx_pend) w_rx_next = RX_WAIT;
      RX_WAIT:   if (r_rx_cnt <= CNT_W'(1)) w_rx_next = RX_SAMPLE;
      RX_SAMPLE: w_rx_next = (r_rx_idx == LAST_IDX) ? RX_HOLD : RX_WAIT;
      RX_HOLD:   if (rx_ready_i) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_word  <= '0;
      r_rd_flk   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      // One request may queue behind a busy word; further ones are dropped.
      if (r_rx_state == RX_IDLE) begin
        r_rx_pend <= 1'b0;
      end else if (w_wr_evt) begin
        r_rx_pend <= 1'b1;
      end
      case (r_rx_state)
        RX_IDLE: if (w_rx_next == RX_WAIT) r_rx_cnt <= GAP;
        RX_WAIT: r_rx_cnt <= r_rx_cnt - 1'b1;
        RX_SAMPLE: begin
          r_rx_word[{r_rx_idx, 3'b000} +: 8] <= chan_rx_data_i;
          r_rd_flk <= ~r_rd_flk;
          r_rx_idx <= r_rx_idx + 1'b1;
          r_rx_cnt <= GAP;
        end
        default: ;
      endcase
    end
  end

  tx_state_t         r_tx_state, w_tx_next;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [IDX_W-1:0]  r_tx_idx;
  logic [31:0]       r_tx_buf;
  logic [7:0]        r_tx_data;
  logic              r_wr_flk;
  logic              r_tx_en;
  logic              w_tx_ready;

  // r_tx_en keeps ready low through reset and raises it on the first edge after.
  assign w_tx_ready = r_tx_en && (r_tx_state == TX_IDLE);

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:     if (tx_valid_i && w_tx_ready) w_tx_next = TX_SEND;
      TX_SEND:     w_tx_next = TX_GAP;
      TX_GAP:      if (r_tx_cnt <= CNT_W'(1))
                     w_tx_next = (r_tx_idx == '0) ? TX_WAIT_ACK : TX_SEND;
      TX_WAIT_ACK: if (w_rd_evt) w_tx_next = TX_IDLE;
      default:     w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_buf   <= '0;
      r_tx_data  <= '0;
      r_wr_flk   <= 1'b0;
      r_tx_en    <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_en    <= 1'b1;
      case (r_tx_state)
        TX_IDLE: if (tx_valid_i && w_tx_ready) r_tx_buf <= tx_word_i;
        TX_SEND: begin
          r_tx_data <= r_tx_buf[{r_tx_idx, 3'b000} +: 8];
          r_wr_flk  <= ~r_wr_flk;
          r_tx_idx  <= r_tx_idx + 1'b1;
          r_tx_cnt  <= GAP;
        end
        TX_GAP: r_tx_cnt <= r_tx_cnt - 1'b1;
        TX_WAIT_ACK: if (w_rd_evt) r_tx_data <= '0;
        default: ;
      endcase
    end
  end

  assign pulpino_read_flicker_o  = r_rd_flk;
  assign pulpino_write_flicker_o = r_wr_flk;
  assign chan_tx_data_o          = r_tx_data;
  assign rx_word_o               = r_rx_word;
  assign rx_valid_o              = (r_rx_state == RX_HOLD);
  assign tx_ready_o              = w_tx_ready;
endmodule

// File: doc/gpio_channel_endpoint.md
GPIO_CHANNEL_ENDPOINT -- requirements
Module: gpio_channel_endpoint

Interface
REQ-001 Parameter FLICKER_GAP, default 2, is the clock cycles between successive flicker toggles and the wait before sampling channel data (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 chan_rx_data_i  input  8  current USB->Pulpino byte presented by the channel.
REQ-005 usb_write_flicker_i  input  1  toggles once per 32-bit word written by USB.
REQ-006 pulpino_read_flicker_o  output  1  toggles once per byte consumed.
REQ-007 chan_tx_data_o  output  8  Pulpino->USB byte presented to the channel.
REQ-008 pulpino_write_flicker_o  output  1  toggles once per byte presented.
REQ-009 usb_read_flicker_i  input  1  toggles once per 32-bit word read by USB.
REQ-010 rx_word_o / rx_valid_o / rx_ready_i  output 32 / output 1 / input 1  received word, valid/ready handshake to core.
REQ-011 tx_word_i / tx_valid_i / tx_ready_o  input 32 / input 1 / output 1  word to send, valid/ready handshake from core.

Function
REQ-012 Each flicker input is edge-detected: an event is one cycle where the registered value differs from its previous registered value; both toggle directions count.
REQ-013 Byte order on both paths is LSB first: byte0 = bits[7:0], byte3 = bits[31:24].
REQ-014 RX FSM states: RX_IDLE, RX_WAIT, RX_SAMPLE, RX_HOLD.
REQ-015 On a usb_write_flicker event in RX_IDLE, go to RX_WAIT and load a counter with FLICKER_GAP.
REQ-016 RX_WAIT: on counter expiry, go to RX_SAMPLE.
REQ-017 RX_SAMPLE (one cycle): capture chan_rx_data_i into the byte slot given by the byte index, toggle pulpino_read_flicker_o, and increment the index.
REQ-018 From RX_SAMPLE: if the index was 3, go to RX_HOLD; otherwise reload the counter and return to RX_WAIT.
REQ-019 RX_HOLD asserts rx_valid_o with rx_word_o held stable.
REQ-020 RX_HOLD exits to RX_IDLE on the cycle where rx_valid_o && rx_ready_i; exactly 4 read_flicker toggles occur per word.
REQ-021 A usb_write_flicker event outside RX_IDLE sets a single pending flag, which is consumed on the next RX_IDLE entry; a second event while the flag is already set is dropped.
REQ-022 TX FSM states: TX_IDLE, TX_SEND, TX_GAP, TX_WAIT_ACK. tx_ready_o = 1 only in TX_IDLE.
REQ-023 On tx_valid_i && tx_ready_o, latch tx_word_i and go to TX_SEND.
REQ-024 TX_SEND: drive the indexed byte on chan_tx_data_o, toggle pulpino_write_flicker_o in the same cycle, then go to TX_GAP for FLICKER_GAP cycles.
REQ-025 After TX_GAP: go to TX_WAIT_ACK if 4 bytes have been sent, otherwise return to TX_SEND.
REQ-026 chan_tx_data_o holds its value until the next TX_SEND and is 8'h00 in TX_IDLE.
REQ-027 TX_WAIT_ACK returns to TX_IDLE on a usb_read_flicker event; an event in any other TX state is ignored.
REQ-028 RX and TX paths are fully independent; simultaneous events on both are each processed in the same cycle.

Reset
REQ-029 Reset asserted at any time, including mid-word, forces: both FSMs to IDLE, both flicker outputs 0, rx_word_o 0, rx_valid_o 0, tx_ready_o 0 while reset is asserted, chan_tx_data_o 0, counters, indices and the pending flag cleared, and edge-detect registers 0.
REQ-030 tx_ready_o rises on the first clock edge after reset deassertion.
REQ-031 Partially assembled words are discarded on reset, not resumed.

Configuration
REQ-032 With GPIO_CHANNEL_SYNC_EN defined, each flicker input passes through a 2-flop synchronizer before edge detection, giving a 3-cycle event latency.
REQ-033 Without GPIO_CHANNEL_SYNC_EN, a single register is used, giving a 2-cycle event latency; all other behaviour is identical.

Structure
REQ-034 Package gpio_channel_pkg holds the RX/TX state enums, BYTES_PER_WORD = 4, and the counter width.
REQ-035 Sub-module flicker_detect (optional synchronizer plus toggle-to-pulse) is instantiated once per flicker input.

Verification
REQ-036 Basic RX: USB word 0x1234ABCD with bytes CD, AB, 34, 12 presented per read toggle -> rx_word_o = 0x1234ABCD, exactly 4 read toggles, rx_valid_o held until rx_ready_i.
REQ-037 Basic TX: tx_word_i = 0xFFCCDDAA -> chan_tx_data_o sequence AA, DD, CC, FF with 4 write toggles spaced FLICKER_GAP+1 cycles, tx_ready_o low until a usb_read_flicker toggle.
REQ-038 RX backpressure: second usb_write_flicker toggle while rx_ready_i = 0 -> second word assembled only after the first is accepted; a third toggle in that window is dropped.
REQ-039 Concurrent traffic: RX of 0xFFCCDDAA overlapping TX of 0x1234ABCD -> both words correct, no cross-interference.
REQ-040 Reset mid-word: reset_n_i low after 2 RX bytes -> outputs at reset values; the next word starts at byte0.
REQ-041 Macro variation: run REQ-036 with and without GPIO_CHANNEL_SYNC_EN -> first read toggle 1 cycle later when the macro is defined.
